// File: rtl/othello_pkg.sv
// Shared Othello definitions: cell encodings, board geometry, direction
// delta tables and the move_validator state encodings.
package othello_pkg;

    localparam int BOARD_DIM = 8;
    localparam int COORD_W   = 3;
    localparam int CELL_W    = 2;

    localparam logic [CELL_W-1:0] CELL_EMPTY = 2'b00;
    localparam logic [CELL_W-1:0] CELL_BLACK = 2'b01;
    localparam logic [CELL_W-1:0] CELL_WHITE = 2'b10;

    // Two-bit signed deltas packed dir7..dir0; dir order is
    // (-1,-1) (0,-1) (1,-1) (-1,0) (1,0) (-1,1) (0,1) (1,1).
    localparam logic [15:0] DX_TABLE = 16'b01_00_11_01_11_01_00_11;
    localparam logic [15:0] DY_TABLE = 16'b01_01_01_00_00_11_11_11;

    localparam int STATE_W = 4;
    localparam logic [STATE_W-1:0] S_IDLE     = 4'd0;
    localparam logic [STATE_W-1:0] S_RD_TGT   = 4'd1;
    localparam logic [STATE_W-1:0] S_CHK_TGT  = 4'd2;
    localparam logic [STATE_W-1:0] S_DIR_INIT = 4'd3;
    localparam logic [STATE_W-1:0] S_STEP_RD  = 4'd4;
    localparam logic [STATE_W-1:0] S_STEP_CHK = 4'd5;
    localparam logic [STATE_W-1:0] S_FLIP     = 4'd6;
    localparam logic [STATE_W-1:0] S_NEXT_DIR = 4'd7;
    localparam logic [STATE_W-1:0] S_PLACE    = 4'd8;
    localparam logic [STATE_W-1:0] S_ACK      = 4'd9;
    localparam logic [STATE_W-1:0] S_REJECT   = 4'd10;
    localparam logic [STATE_W-1:0] S_HOLD     = 4'd11;

    function automatic logic [1:0] dir_dx(input logic [2:0] dir);
        return DX_TABLE[{dir, 1'b0} +: 2];
    endfunction

    function automatic logic [1:0] dir_dy(input logic [2:0] dir);
        return DY_TABLE[{dir, 1'b0} +: 2];
    endfunction

    // Reserved encoding 11 counts as empty.
    function automatic logic cell_occupied(input logic [CELL_W-1:0] c);
        return (c == CELL_BLACK) || (c == CELL_WHITE);
    endfunction

endpackage

// File: rtl/move_validator_if.sv
// Controller / board-RAM bus of move_validator.
// Handshake: new_move is a level request carrying player/move_x/move_y;
// the validator holds busy high while working and answers with exactly one
// single-cycle pulse, ack (move committed) or invalid (rejected). It will
// not start another move until new_move drops or the coordinates change.
// Board RAM: rd_data returns the cell at rd_addr one cycle later; a write
// happens on every cycle wr_en is high.
interface move_validator_if;
    import othello_pkg::*;

    logic                   new_move;
    logic                   player;
    logic [COORD_W-1:0]     move_x;
    logic [COORD_W-1:0]     move_y;
    logic [2*COORD_W-1:0]   rd_addr;
    logic [CELL_W-1:0]      rd_data;
    logic                   wr_en;
    logic [2*COORD_W-1:0]   wr_addr;
    logic [CELL_W-1:0]      wr_data;
    logic                   busy;
    logic                   ack;
    logic                   invalid;

    modport master (
        output new_move, player, move_x, move_y, rd_data,
        input  rd_addr, wr_en, wr_addr, wr_data, busy, ack, invalid
    );

    modport slave (
        input  new_move, player, move_x, move_y, rd_data,
        output rd_addr, wr_en, wr_addr, wr_data, busy, ack, invalid
    );

endinterface

// File: rtl/move_validator_board_step.sv
// board_step: one step from (x,y) along direction dir, with an
// off-board flag. Since 2**COORD_W == BOARD_DIM, leaving the board in
// either direction shows up as the carry/borrow bit of the widened sum.
module board_step
    import othello_pkg::*;
(
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [2:0]         dir_i,
    output logic [COORD_W-1:0] nx_o,
    output logic [COORD_W-1:0] ny_o,
    output logic               oob_o
);

    logic [1:0]       dx;
    logic [1:0]       dy;
    logic [COORD_W:0] sum_x;
    logic [COORD_W:0] sum_y;

    // Sign-extend the delta and add it to the zero-extended coordinate.
    always_comb begin
        dx    = dir_dx(dir_i);
        dy    = dir_dy(dir_i);
        sum_x = {1'b0, x_i} + {{(COORD_W-1){dx[1]}}, dx};
        sum_y = {1'b0, y_i} + {{(COORD_W-1){dy[1]}}, dy};
        nx_o  = sum_x[COORD_W-1:0];
        ny_o  = sum_y[COORD_W-1:0];
        oob_o = sum_x[COORD_W] | sum_y[COORD_W];
    end

endmodule

// File: rtl/move_validator.sv
// move_validator: checks one Othello move against the board RAM, flips
// the captured discs direction by direction, places the new disc and
// pulses ack, or pulses invalid with the board untouched.
// Optional build macro FLIP_COUNT_EN adds the flip_count output.
module move_validator
    import othello_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    move_validator_if.slave      bus,
    output logic [STATE_W-1:0]   dbg_state_o
`ifdef FLIP_COUNT_EN
    ,
    output logic [2*COORD_W-1:0] flip_count
`endif
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CELL_W-1:0]  colour_q, colour_d;
    logic [COORD_W-1:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [2:0]         dir_q, dir_d;
    logic [COORD_W-1:0] run_len_q, run_len_d;
    logic [COORD_W-1:0] flip_cnt_q, flip_cnt_d;
    logic               any_flip_q, any_flip_d;

    logic [COORD_W-1:0] step_x, step_y;
    logic               step_oob;
    logic [CELL_W-1:0]  opp_colour;

    logic [2*COORD_W-1:0] rd_addr, wr_addr;
    logic                 wr_en;
    logic [CELL_W-1:0]    wr_data;

    // One step from the current cursor; serves both the scan and the flips.
    board_step u_step (
        .x_i   (cur_x_q),
        .y_i   (cur_y_q),
        .dir_i (dir_q),
        .nx_o  (step_x),
        .ny_o  (step_y),
        .oob_o (step_oob)
    );

    assign opp_colour = colour_q ^ 2'b11;

    // Next-state and RAM strobes for the scan/flip sequencer.
    always_comb begin
        state_d    = state_q;
        colour_d   = colour_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        dir_d      = dir_q;
        run_len_d  = run_len_q;
        flip_cnt_d = flip_cnt_q;
        any_flip_d = any_flip_q;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.new_move) begin
                    colour_d = {1'b0, bus.player} + 2'd1;
                    tgt_x_d  = bus.move_x;
                    tgt_y_d  = bus.move_y;
                    state_d  = S_RD_TGT;
                end
            end
            S_RD_TGT: begin
                rd_addr = {tgt_y_q, tgt_x_q};
                state_d = S_CHK_TGT;
            end
            S_CHK_TGT: begin
                if (cell_occupied(bus.rd_data)) begin
                    state_d = S_REJECT;
                end else begin
                    dir_d      = '0;
                    any_flip_d = 1'b0;
                    state_d    = S_DIR_INIT;
                end
            end
            S_DIR_INIT: begin
                run_len_d = '0;
                cur_x_d   = tgt_x_q;
                cur_y_d   = tgt_y_q;
                state_d   = S_STEP_RD;
            end
            S_STEP_RD: begin
                if (step_oob) begin
                    state_d = S_NEXT_DIR;
                end else begin
                    rd_addr = {step_y, step_x};
                    cur_x_d = step_x;
                    cur_y_d = step_y;
                    state_d = S_STEP_CHK;
                end
            end
            S_STEP_CHK: begin
                if (bus.rd_data == opp_colour) begin
                    run_len_d = run_len_q + COORD_W'(1);
                    state_d   = S_STEP_RD;
                end else if (bus.rd_data == colour_q && run_len_q != '0) begin
                    flip_cnt_d = run_len_q;
                    cur_x_d    = tgt_x_q;
                    cur_y_d    = tgt_y_q;
                    state_d    = S_FLIP;
                end else begin
                    state_d = S_NEXT_DIR;
                end
            end
            S_FLIP: begin
                wr_en      = 1'b1;
                wr_addr    = {step_y, step_x};
                wr_data    = colour_q;
                cur_x_d    = step_x;
                cur_y_d    = step_y;
                flip_cnt_d = flip_cnt_q - COORD_W'(1);
                if (flip_cnt_q == COORD_W'(1)) begin
                    any_flip_d = 1'b1;
                    state_d    = S_NEXT_DIR;
                end
            end
            S_NEXT_DIR: begin
                if (dir_q != 3'd7) begin
                    dir_d   = dir_q + 3'd1;
                    state_d = S_DIR_INIT;
                end else if (any_flip_q) begin
                    state_d = S_PLACE;
                end else begin
                    state_d = S_REJECT;
                end
            end
            S_PLACE: begin
                wr_en   = 1'b1;
                wr_addr = {tgt_y_q, tgt_x_q};
                wr_data = colour_q;
                state_d = S_ACK;
            end
            S_ACK:    state_d = S_HOLD;
            S_REJECT: state_d = S_HOLD;
            S_HOLD: begin
                if (!bus.new_move || bus.move_x != tgt_x_q || bus.move_y != tgt_y_q) begin
                    state_d = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // State and working registers; reset aborts any move in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            colour_q   <= '0;
            tgt_x_q    <= '0;
            tgt_y_q    <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            dir_q      <= '0;
            run_len_q  <= '0;
            flip_cnt_q <= '0;
            any_flip_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            colour_q   <= colour_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            dir_q      <= dir_d;
            run_len_q  <= run_len_d;
            flip_cnt_q <= flip_cnt_d;
            any_flip_q <= any_flip_d;
        end
    end

`ifdef FLIP_COUNT_EN
    logic [2*COORD_W-1:0] flip_count_q;

    // Running total of flip writes, cleared when a move starts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flip_count_q <= '0;
        end else if (state_q == S_IDLE && bus.new_move) begin
            flip_count_q <= '0;
        end else if (state_q == S_FLIP) begin
            flip_count_q <= flip_count_q + (2*COORD_W)'(1);
        end
    end

    assign flip_count = flip_count_q;
`endif

    assign bus.rd_addr = rd_addr;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.ack     = (state_q == S_ACK);
    assign bus.invalid = (state_q == S_REJECT);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_move_validator.sv
// Bench for move_validator: board RAM model, Othello reference model
// feeding an expected-write queue, table of directed moves, a few
// multi-cycle sequences (retry re-arm, reset mid-flip) and random boards.
module tb_move_validator;
  import othello_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [STATE_W-1:0] dbg_state;
`ifdef FLIP_COUNT_EN
  logic [5:0] flip_count;
`endif

  move_validator_if bus();

  move_validator dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
`ifdef FLIP_COUNT_EN
    ,
    .flip_count  (flip_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- board RAM model ----------------
  logic [1:0] mem [64];
  logic [1:0] ld_img [64];
  logic       ld_en = 1'b0;

  always @(posedge clock) begin
    if (ld_en) begin
      for (int i = 0; i < 64; i++) mem[i] <= ld_img[i];
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
    bus.rd_data <= mem[bus.rd_addr];
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [1:0] ref_b [64];
  int checks = 0;
  int errors = 0;
  int dxs [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
  int dys [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // sel: 0 start, 1 row B+6W, 2 W run to edge, 3 start with reserved at (3,2), 4 random
  task automatic load_board(input int sel);
    for (int i = 0; i < 64; i++) ld_img[i] = 2'b00;
    case (sel)
      0, 3: begin
        ld_img[3*8+3] = 2'b10; ld_img[3*8+4] = 2'b01;
        ld_img[4*8+3] = 2'b01; ld_img[4*8+4] = 2'b10;
        if (sel == 3) ld_img[2*8+3] = 2'b11;
      end
      1: begin
        ld_img[0] = 2'b01;
        for (int i = 1; i <= 6; i++) ld_img[i] = 2'b10;
      end
      2: for (int i = 1; i <= 7; i++) ld_img[i] = 2'b10;
      default: for (int i = 0; i < 64; i++) ld_img[i] = 2'($urandom_range(0, 3));
    endcase
    for (int i = 0; i < 64; i++) ref_b[i] = ld_img[i];
    ld_en = 1'b1;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  // Othello rules on ref_b; pushes every expected RAM write in order.
  task automatic model_move(input logic pl, input int x, input int y,
                            output int e_ack, output int e_flips);
    logic [1:0] col, opp;
    int cx, cy, n;
    col = pl ? 2'b10 : 2'b01;
    opp = pl ? 2'b01 : 2'b10;
    e_ack = 0;
    e_flips = 0;
    if (ref_b[y*8+x] == 2'b01 || ref_b[y*8+x] == 2'b10) return;
    for (int d = 0; d < 8; d++) begin
      n = 0;
      cx = x + dxs[d];
      cy = y + dys[d];
      while (cx >= 0 && cx < 8 && cy >= 0 && cy < 8 && ref_b[cy*8+cx] == opp) begin
        n++;
        cx += dxs[d];
        cy += dys[d];
      end
      if (cx >= 0 && cx < 8 && cy >= 0 && cy < 8 && ref_b[cy*8+cx] == col && n > 0) begin
        for (int k = 1; k <= n; k++) begin
          int a;
          a = (y + k*dys[d])*8 + (x + k*dxs[d]);
          ref_b[a] = col;
          exp_q.push_back({a[5:0], col});
          e_flips++;
        end
      end
    end
    if (e_flips > 0) begin
      e_ack = 1;
      ref_b[y*8+x] = col;
      exp_q.push_back({6'(y*8+x), col});
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_move(input logic pl, input int x, input int y,
                          input int exp_ack, input int exp_flips, input int exp_lat,
                          input int lat_off, input string tag, input bit keep);
    int cyc, n_ack, n_inv, lat, ovl, bad;
    bit done;
    n_ack = 0; n_inv = 0; lat = -1; ovl = 0; done = 0; cyc = 0;
    bus.new_move = 1'b1;
    bus.player   = pl;
    bus.move_x   = 3'(x);
    bus.move_y   = 3'(y);
    while (!done && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1 + lat_off) check({tag, " busy"}, int'(bus.busy), 1);
      if (bus.wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s unexpected_write: addr %0d data %0d, none expected",
                   tag, bus.wr_addr, bus.wr_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check({tag, " write"}, int'({bus.wr_addr, bus.wr_data}), int'(e));
        end
      end
      if (bus.ack) n_ack++;
      if (bus.invalid) begin
        n_inv++;
        lat = cyc;
      end
      if ((bus.wr_en && (bus.ack || bus.invalid)) || (bus.ack && bus.invalid)) ovl++;
      if (dbg_state == S_HOLD) done = 1;
    end
    check({tag, " reach_hold"}, int'(done), 1);
    check({tag, " ack_count"}, n_ack, exp_ack);
    check({tag, " invalid_count"}, n_inv, 1 - exp_ack);
    if (exp_lat >= 0) check({tag, " invalid_latency"}, lat, exp_lat + lat_off);
    check({tag, " pulse_overlap"}, ovl, 0);
`ifdef FLIP_COUNT_EN
    check({tag, " flip_count"}, int'(flip_count), exp_flips);
`else
    if (exp_flips < 0) $display("note: negative flip expectation in %s", tag);
`endif
    check({tag, " writes_left"}, exp_q.size(), 0);
    exp_q.delete();
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_b[i]) bad++;
    check({tag, " board_cells_wrong"}, bad, 0);
    if (!keep) begin
      bus.new_move = 1'b0;
      cyc = 0;
      do begin
        @(negedge clock);
        cyc++;
      end while (bus.busy && cyc < 20);
      check({tag, " idle_after_release"}, int'(bus.busy), 0);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int   sel;
    logic pl;
    int   x;
    int   y;
    int   ack;
    int   flips;
    int   lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int m_ack, m_flips, cyc;
    bit seen;

    vecs[0] = '{0, 1'b0, 3, 2, 1, 1, -1};  // black captures (3,3) vertically
    vecs[1] = '{0, 1'b0, 3, 3, 0, 0, 3};   // occupied target
    vecs[2] = '{0, 1'b0, 0, 0, 0, 0, -1};  // corner, nothing to capture
    vecs[3] = '{1, 1'b0, 7, 0, 1, 6, -1};  // six-disc run along row 0
    vecs[4] = '{2, 1'b0, 0, 0, 0, 0, -1};  // run hits board edge
    vecs[5] = '{0, 1'b1, 4, 2, 1, 1, -1};  // white captures (4,3)
    vecs[6] = '{0, 1'b1, 2, 2, 0, 0, -1};  // adjacent own disc, run 0
    vecs[7] = '{3, 1'b0, 3, 2, 1, 1, -1};  // reserved target counts as empty

    bus.new_move = 1'b0;
    bus.player   = 1'b0;
    bus.move_x   = '0;
    bus.move_y   = '0;

    // reset state
    repeat (2) @(negedge clock);
    check("reset rd_addr", int'(bus.rd_addr), 0);
    check("reset wr_en", int'(bus.wr_en), 0);
    check("reset wr_addr", int'(bus.wr_addr), 0);
    check("reset wr_data", int'(bus.wr_data), 0);
    check("reset ack", int'(bus.ack), 0);
    check("reset invalid", int'(bus.invalid), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset state", int'(dbg_state), int'(S_IDLE));
`ifdef FLIP_COUNT_EN
    check("reset flip_count", int'(flip_count), 0);
`endif
    reset = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 8; v++) begin
      load_board(vecs[v].sel);
      model_move(vecs[v].pl, vecs[v].x, vecs[v].y, m_ack, m_flips);
      run_move(vecs[v].pl, vecs[v].x, vecs[v].y, vecs[v].ack, vecs[v].flips,
               vecs[v].lat, 0, $sformatf("vec%0d", v), 0);
    end

    // retry: rejected selection, new_move held, coordinates changed -> re-arms
    load_board(0);
    model_move(1'b0, 3, 3, m_ack, m_flips);
    run_move(1'b0, 3, 3, 0, 0, 3, 0, "retry_first", 1);
    model_move(1'b0, 3, 2, m_ack, m_flips);
    run_move(1'b0, 3, 2, 1, 1, -1, 1, "retry_second", 0);

    // reset mid-FLIP aborts at once
    load_board(1);
    bus.new_move = 1'b1;
    bus.player   = 1'b0;
    bus.move_x   = 3'd7;
    bus.move_y   = 3'd0;
    seen = 0;
    cyc = 0;
    while (!seen && cyc < 500) begin
      @(negedge clock);
      cyc++;
      if (dbg_state == S_FLIP) seen = 1;
    end
    check("midflip reached_flip", int'(seen), 1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midflip wr_en", int'(bus.wr_en), 0);
    check("midflip busy", int'(bus.busy), 0);
    check("midflip state", int'(dbg_state), int'(S_IDLE));
    check("midflip ack", int'(bus.ack), 0);
`ifdef FLIP_COUNT_EN
    check("midflip flip_count", int'(flip_count), 0);
`endif
    exp_q.delete();
    load_board(0);
    bus.move_x = 3'd3;
    bus.move_y = 3'd2;
    @(negedge clock);
    reset = 1'b1;
    model_move(1'b0, 3, 2, m_ack, m_flips);
    run_move(1'b0, 3, 2, 1, 1, -1, 0, "after_reset", 0);

    // random boards and moves checked against the reference model
    for (int r = 0; r < 24; r++) begin
      logic pl;
      int x, y;
      load_board(4);
      pl = 1'($urandom_range(0, 1));
      x  = $urandom_range(0, 7);
      y  = $urandom_range(0, 7);
      model_move(pl, x, y, m_ack, m_flips);
      run_move(pl, x, y, m_ack, m_flips, -1, 0, $sformatf("rand%0d", r), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
